decode_buffer: RTL and testbench

- Multi-wide decode stage between the fetch stage and issue.
- Accepts fetch bundles of up to FETCH_WIDTH raw RV64 instructions and holds them in a circular instruction queue of DEPTH entries.
- Presents the oldest DECODE_WIDTH entries as decoded instructions, each with its PC and an illegal-instruction flag.
- Supports partial dequeue, simultaneous enqueue and dequeue, and a single-cycle flush on redirect.

---
 rtl/decode_pkg.sv | 65 ++++++
 rtl/decode_buffer_decoder.sv | 109 ++++++++++
 rtl/decode_buffer.sv | 74 +++++++
 tb/tb_decode_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, micro-op encoding, decoded record
// and the queue entry used by decode_buffer.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_PRIV   = 7'b1110011;

    localparam logic [2:0] F3_FENCE        = 3'b000;
    localparam logic [2:0] F3_FENCEI       = 3'b001;
    localparam logic [2:0] F3_ECALL_EBREAK = 3'b000;

    typedef enum logic [3:0] {
        UOP_NONE, UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BRANCH, UOP_LOAD,
        UOP_STORE, UOP_ADDI, UOP_ALU_IMM, UOP_ADD, UOP_ALU, UOP_MUL, UOP_DIV,
        UOP_FENCE, UOP_SYSTEM
    } uop_e;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic muldiv;
        logic word;
        logic use_imm;
    } control_t;

    typedef struct packed {
        uop_e               uop;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         f3;
        logic signed [63:0] imm;
        control_t           ctl;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0] raw;
        logic [63:0] pc;
    } decode_buf_entry_t;

    // FENCE and ECALL/EBREAK carry no datapath control, so they are
    // recognised here by exact encoding rather than through ctl.
    function automatic logic is_legal(logic [31:0] raw, control_t ctl);
        return (ctl != '0)
            || (raw[6:0] == OP_FENCE && (raw[14:12] == F3_FENCE || raw[14:12] == F3_FENCEI))
            || (raw[6:0] == OP_PRIV && raw[14:12] == F3_ECALL_EBREAK
                && (raw[31:20] == 12'h000 || raw[31:20] == 12'h001)
                && raw[19:15] == 5'd0 && raw[11:7] == 5'd0);
    endfunction

endpackage

// File: rtl/decode_buffer_decoder.sv
// Combinational RV64IM decoder for one lane; ctl stays zero for any
// encoding it does not recognise.
module decode_buffer_decoder
    import decode_pkg::*;
(
    input  logic [31:0]    raw,
    output decoded_instr_t dec
);
    logic [6:0]         opcode;
    logic [6:0]         f7;
    logic [2:0]         f3;
    logic signed [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic               shamt64_ok, shamt32_ok;
    logic               ok;
    control_t           ctl;
    uop_e               uop;
    logic signed [63:0] imm;

    assign opcode = raw[6:0];
    assign f3     = raw[14:12];
    assign f7     = raw[31:25];
    assign imm_i  = {{52{raw[31]}}, raw[31:20]};
    assign imm_s  = {{52{raw[31]}}, raw[31:25], raw[11:7]};
    assign imm_b  = {{52{raw[31]}}, raw[7], raw[30:25], raw[11:8], 1'b0};
    assign imm_u  = {{32{raw[31]}}, raw[31:12], 12'h000};
    assign imm_j  = {{44{raw[31]}}, raw[19:12], raw[20], raw[30:21], 1'b0};

    // 64-bit shifts use a 6-bit shamt; only SRAI/SRAIW may set the arith bit
    assign shamt64_ok = raw[31:26] == 6'h00 || (f3 == 3'b101 && raw[31:26] == 6'h10);
    assign shamt32_ok = f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20);

    always_comb begin
        ok  = 1'b1;
        ctl = '0;
        uop = UOP_NONE;
        imm = '0;
        case (opcode)
            OP_LUI:    begin uop = UOP_LUI;   imm = imm_u; ctl.alu = 1'b1; ctl.use_imm = 1'b1; end
            OP_AUIPC:  begin uop = UOP_AUIPC; imm = imm_u; ctl.alu = 1'b1; ctl.use_imm = 1'b1; end
            OP_JAL:    begin uop = UOP_JAL;   imm = imm_j; ctl.jump = 1'b1; end
            OP_JALR: begin
                uop = UOP_JALR; imm = imm_i; ctl.jump = 1'b1; ctl.use_imm = 1'b1;
                ok  = f3 == 3'b000;
            end
            OP_BRANCH: begin
                uop = UOP_BRANCH; imm = imm_b; ctl.branch = 1'b1;
                ok  = f3 != 3'b010 && f3 != 3'b011;
            end
            OP_LOAD: begin
                uop = UOP_LOAD; imm = imm_i; ctl.load = 1'b1; ctl.use_imm = 1'b1;
                ok  = f3 != 3'b111;
            end
            OP_STORE: begin
                uop = UOP_STORE; imm = imm_s; ctl.store = 1'b1; ctl.use_imm = 1'b1;
                ok  = !f3[2];
            end
            OP_IMM: begin
                uop = (f3 == 3'b000) ? UOP_ADDI : UOP_ALU_IMM;
                imm = imm_i; ctl.alu = 1'b1; ctl.use_imm = 1'b1;
                ok  = (f3 != 3'b001 && f3 != 3'b101) || shamt64_ok;
            end
            OP_IMM32: begin
                uop = UOP_ALU_IMM; imm = imm_i;
                ctl.alu = 1'b1; ctl.use_imm = 1'b1; ctl.word = 1'b1;
                ok  = f3 == 3'b000 || ((f3 == 3'b001 || f3 == 3'b101) && shamt32_ok);
            end
            OP_REG: begin
                case (f7)
                    7'h00: begin uop = (f3 == 3'b000) ? UOP_ADD : UOP_ALU; ctl.alu = 1'b1; end
                    7'h20: begin uop = UOP_ALU; ctl.alu = 1'b1; ok = f3 == 3'b000 || f3 == 3'b101; end
                    // Multiply unit supports MUL and the divide group only
                    7'h01: begin
                        uop = f3[2] ? UOP_DIV : UOP_MUL; ctl.muldiv = 1'b1;
                        ok  = f3 == 3'b000 || f3[2];
                    end
                    default: ok = 1'b0;
                endcase
            end
            OP_REG32: begin
                ctl.word = 1'b1;
                case (f7)
                    7'h00: begin
                        uop = UOP_ALU; ctl.alu = 1'b1;
                        ok  = f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101;
                    end
                    7'h20: begin uop = UOP_ALU; ctl.alu = 1'b1; ok = f3 == 3'b000 || f3 == 3'b101; end
                    7'h01: begin
                        uop = f3[2] ? UOP_DIV : UOP_MUL; ctl.muldiv = 1'b1;
                        ok  = f3 == 3'b000 || f3[2];
                    end
                    default: ok = 1'b0;
                endcase
            end
            OP_FENCE: uop = UOP_FENCE;
            OP_PRIV:  uop = UOP_SYSTEM;
            default:  ok = 1'b0;
        endcase

        dec     = '0;
        dec.uop = ok ? uop : UOP_NONE;
        dec.rd  = raw[11:7];
        dec.rs1 = raw[19:15];
        dec.rs2 = raw[24:20];
        dec.f3  = f3;
        dec.imm = imm;
        dec.ctl = ok ? ctl : '0;
    end

endmodule

// File: rtl/decode_buffer.sv
// Circular instruction queue between fetch and issue; presents the oldest
// DECODE_WIDTH entries decoded, with PC and illegal-instruction flag.
module decode_buffer
    import decode_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   in_count,
    input  logic [FETCH_WIDTH*32-1:0]          in_instr,
    input  logic [63:0]                        in_pc,
    output logic [DECODE_WIDTH-1:0]            out_valid,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]  out_accept,
    output decoded_instr_t [DECODE_WIDTH-1:0]  out_instr,
    output logic [DECODE_WIDTH*64-1:0]         out_pc,
    output logic [DECODE_WIDTH-1:0]            out_illegal
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INC_W = $clog2(FETCH_WIDTH + 1);

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              enq;
    logic [CNT_W-1:0]  enq_n, deq_n;
    decode_buf_entry_t entries [DEPTH];
    decode_buf_entry_t lane_entry [DECODE_WIDTH];

    // Registered count only, so out_accept never reaches in_ready
    assign in_ready = count <= CNT_W'(DEPTH - FETCH_WIDTH);
    assign enq      = in_valid && in_ready && !flush;
    assign enq_n    = enq ? CNT_W'(in_count) : '0;
    assign deq_n    = CNT_W'(out_accept);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq && INC_W'(i) < in_count) begin
                entries[tail + PTR_W'(i)] <= '{raw: in_instr[32*i +: 32], pc: in_pc + 64'(4 * i)};
            end
        end
    end

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        assign lane_entry[g]       = entries[head + PTR_W'(g)];
        assign out_valid[g]        = count > CNT_W'(g);
        assign out_pc[64*g +: 64]  = lane_entry[g].pc;

        decode_buffer_decoder u_dec (
            .raw (lane_entry[g].raw),
            .dec (out_instr[g])
        );

        assign out_illegal[g] = out_valid[g] && !is_legal(lane_entry[g].raw, out_instr[g].ctl);
    end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed table-driven bench for decode_buffer (FETCH_WIDTH=2, DECODE_WIDTH=2, DEPTH=8).
module tb_decode_buffer;
    import decode_pkg::*;

    localparam logic [31:0] I_ADDI5  = 32'h00500093;
    localparam logic [31:0] I_ADD    = 32'h00108133;
    localparam logic [31:0] I_ADDIM1 = 32'hFFF00093;
    localparam logic [31:0] I_SD     = 32'h00113423;
    localparam logic [31:0] I_MULH   = 32'h02101033;
    localparam logic [31:0] I_ONES   = 32'hFFFFFFFF;
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_BADSYS = 32'h00200073;

    logic                  clk = 1'b0;
    logic                  reset, flush, in_valid, in_ready;
    logic [1:0]            in_count;
    logic [63:0]           in_instr;
    logic [63:0]           in_pc;
    logic [1:0]            out_valid;
    logic [1:0]            out_accept;
    decoded_instr_t [1:0]  out_instr;
    logic [127:0]          out_pc;
    logic [1:0]            out_illegal;

    int n_vec = 0;
    int n_bad = 0;

    decode_buffer #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_accept  (out_accept),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Consumer must never accept more lanes than are valid
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            assert (out_accept <= 2'($countones(out_valid)))
            else begin
                $display("FAIL protocol: out_accept %0d exceeds valid lanes %b", out_accept, out_valid);
                n_bad++;
            end
        end
    end

    typedef struct {
        logic        rst, fl, vld;
        logic [1:0]  cnt;
        logic [31:0] i0, i1;
        logic [63:0] pc;
        logic [1:0]  acc;
        logic [1:0]  ev;
        logic        erdy;
        logic [63:0] epc0, epc1;
        logic [1:0]  eill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic vld, logic [1:0] cnt,
                                logic [31:0] i0, logic [31:0] i1, logic [63:0] pc,
                                logic [1:0] acc, logic [1:0] ev, logic erdy,
                                logic [63:0] epc0, logic [63:0] epc1, logic [1:0] eill);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld; v.cnt = cnt; v.i0 = i0; v.i1 = i1;
        v.pc = pc; v.acc = acc; v.ev = ev; v.erdy = erdy;
        v.epc0 = epc0; v.epc1 = epc1; v.eill = eill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        reset      = v.rst;
        flush      = v.fl;
        in_valid   = v.vld;
        in_count   = v.cnt;
        in_instr   = {v.i1, v.i0};
        in_pc      = v.pc;
        out_accept = v.acc;
        @(posedge clk);
        #1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_accept = 2'd0;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(v.ev));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(v.erdy));
        if (v.ev[0]) begin
            chk({tag, " pc0"}, out_pc[63:0], v.epc0);
            chk({tag, " ill0"}, 64'(out_illegal[0]), 64'(v.eill[0]));
        end
        if (v.ev[1]) begin
            chk({tag, " pc1"}, out_pc[127:64], v.epc1);
            chk({tag, " ill1"}, 64'(out_illegal[1]), 64'(v.eill[1]));
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = 2'd0;
        in_instr = '0; in_pc = '0; out_accept = 2'd0;

        // reset, then fill to full; the bundle offered while full is dropped
        vecs.push_back(mk(1,0,0,0, I_ADDI5,I_ADD, 64'h0,          0, 2'b00,1, 64'h0,          64'h0,          2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000000,   0, 2'b11,1, 64'h80000000,   64'h80000004,   2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000008,   0, 2'b11,1, 64'h80000000,   64'h80000004,   2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000010,   0, 2'b11,1, 64'h80000000,   64'h80000004,   2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000018,   0, 2'b11,0, 64'h80000000,   64'h80000004,   2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000020,   2, 2'b11,1, 64'h80000008,   64'h8000000C,   2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          2, 2'b11,1, 64'h80000010,   64'h80000014,   2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          2, 2'b11,1, 64'h80000018,   64'h8000001C,   2'b00));
        // steady enqueue 2 / accept 2 across the 7->0 index wrap
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000020 + 64'(8*k), 2, 2'b11,1,
                              64'h80000020 + 64'(8*k), 64'h80000024 + 64'(8*k), 2'b00));
        end
        // partial accept with single-instruction bundles, then drain
        vecs.push_back(mk(0,0,1,1, I_ADDI5,I_ADD, 64'h80000070,   0, 2'b11,1, 64'h80000068,   64'h8000006C,   2'b00));
        vecs.push_back(mk(0,0,1,1, I_ADDI5,I_ADD, 64'h80000074,   1, 2'b11,1, 64'h8000006C,   64'h80000070,   2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          2, 2'b01,1, 64'h80000074,   64'h0,          2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          1, 2'b00,1, 64'h0,          64'h0,          2'b00));
        // legality: MULH, all-ones, FENCE, ECALL, bad SYSTEM funct12
        vecs.push_back(mk(0,0,1,2, I_MULH,I_ONES, 64'h90000000,   0, 2'b11,1, 64'h90000000,   64'h90000004,   2'b11));
        vecs.push_back(mk(0,0,1,1, I_FENCE,I_ADD, 64'h90000008,   1, 2'b11,1, 64'h90000004,   64'h90000008,   2'b01));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          1, 2'b01,1, 64'h90000008,   64'h0,          2'b00));
        vecs.push_back(mk(0,0,1,2, I_ECALL,I_BADSYS, 64'h9000000C, 1, 2'b11,1, 64'h9000000C,  64'h90000010,   2'b10));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          2, 2'b00,1, 64'h0,          64'h0,          2'b00));
        // flush at count 5 with a bundle and an accept offered
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'hA0000000,   0, 2'b11,1, 64'hA0000000,   64'hA0000004,   2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'hA0000008,   0, 2'b11,1, 64'hA0000000,   64'hA0000004,   2'b00));
        vecs.push_back(mk(0,0,1,1, I_ADDI5,I_ADD, 64'hA0000010,   0, 2'b11,1, 64'hA0000000,   64'hA0000004,   2'b00));
        vecs.push_back(mk(0,1,1,2, I_ADDI5,I_ADD, 64'hB0000000,   2, 2'b00,1, 64'h0,          64'h0,          2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          0, 2'b00,1, 64'h0,          64'h0,          2'b00));
        vecs.push_back(mk(0,0,1,2, I_ADDI5,I_ADD, 64'hC0000000,   0, 2'b11,1, 64'hC0000000,   64'hC0000004,   2'b00));
        // reset mid-operation wins over flush and drops the offered bundle
        vecs.push_back(mk(1,1,1,2, I_ADDI5,I_ADD, 64'hD0000000,   1, 2'b00,1, 64'h0,          64'h0,          2'b00));
        vecs.push_back(mk(0,0,0,0, I_ADDI5,I_ADD, 64'h0,          0, 2'b00,1, 64'h0,          64'h0,          2'b00));
        vecs.push_back(mk(0,0,1,1, I_ADDI5,I_ADD, 64'hE0000000,   0, 2'b01,1, 64'hE0000000,   64'h0,          2'b00));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // decoded-field checks on a fresh queue
        apply(mk(1,0,0,0, I_ADDI5,I_ADD, 64'h0, 0, 2'b00,1, 64'h0, 64'h0, 2'b00), "dec_rst");
        apply(mk(0,0,1,2, I_ADDI5,I_ADD, 64'h80000000, 0, 2'b11,1, 64'h80000000, 64'h80000004, 2'b00), "dec_a");
        chk("dec_a uop0", 64'(out_instr[0].uop), 64'(UOP_ADDI));
        chk("dec_a imm0", out_instr[0].imm, 64'd5);
        chk("dec_a rd0",  64'(out_instr[0].rd), 64'd1);
        chk("dec_a uop1", 64'(out_instr[1].uop), 64'(UOP_ADD));
        chk("dec_a rd1",  64'(out_instr[1].rd), 64'd2);
        chk("dec_a rs1",  64'(out_instr[1].rs1), 64'd1);
        chk("dec_a rs2",  64'(out_instr[1].rs2), 64'd1);
        apply(mk(0,0,1,2, I_ADDIM1,I_SD, 64'h80000008, 2, 2'b11,1, 64'h80000008, 64'h8000000C, 2'b00), "dec_b");
        chk("dec_b uop0", 64'(out_instr[0].uop), 64'(UOP_ADDI));
        chk("dec_b imm0", out_instr[0].imm, 64'hFFFFFFFFFFFFFFFF);
        chk("dec_b uop1", 64'(out_instr[1].uop), 64'(UOP_STORE));
        chk("dec_b imm1", out_instr[1].imm, 64'd8);
        chk("dec_b rs1",  64'(out_instr[1].rs1), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
